// File: rtl/rfdc_nco_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rfdc_nco_seq_pkg
// Description : Shared types and constants for the RFDC NCO reset sequencer:
//               FSM state encoding and counter widths.
// Ports       : none (package)
// Options     : none
// Revision    : 1.0 - initial release
// ============================================================================
package rfdc_nco_seq_pkg;

  // Sequencer FSM states, 3-bit encoding.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SYNC     = 3'd1,
    ASSERT   = 3'd2,
    WAIT_ACK = 3'd3,
    DONE     = 3'd4
  } seq_state_t;

  // Counter widths.
  localparam int SREF_CNT_W = 4;   // SYSREF skip counter (1..15)
  localparam int REQ_CNT_W  = 8;   // request hold counter (1..255)
  localparam int TMO_CNT_W  = 16;  // ack timeout counter

endpackage : rfdc_nco_seq_pkg
`default_nettype wire

// File: rtl/rfdc_seq_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : rfdc_seq_down_counter
// Description : Loadable down-counter that saturates at zero and flags the
//               terminal count (value == 1). Load has priority over
//               decrement.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_load, i_load_val - load strobe and value
//               i_dec              - decrement enable (no effect at zero)
//               o_tc               - high while the count equals 1
// Options     : none
// Revision    : 1.0 - initial release
// ============================================================================
module rfdc_seq_down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_tc = (r_count == WIDTH'(1));

endmodule : rfdc_seq_down_counter
`default_nettype wire

// File: rtl/rfdc_nco_reset_seq.sv
`default_nettype none
// ============================================================================
// Module      : rfdc_nco_reset_seq
// Description : Sequences a SYSREF-aligned NCO reset across the enabled RFDC
//               tiles. A start strobe arms the sequencer, SYSREF_WAIT SYSREF
//               strobes are counted, then every enabled tile request is held
//               for REQ_CYCLES clocks. The sequencer then waits for all
//               enabled acks (or a timeout) and reports done / error levels.
// Ports       : clk, rst          - control clock, synchronous active-high rst
//               start_nco_reset   - one-cycle start strobe (ignored when busy)
//               sysref_stb        - one-cycle SYSREF strobe, clk domain
//               tile_nco_rst_req  - per-tile reset request
//               tile_nco_rst_ack  - per-tile reset-complete level
//               nco_reset_done    - last sequence finished
//               nco_reset_err     - last sequence timed out
//               seq_busy          - FSM is not idle
//               seq_count         - completed sequences (optional)
//               timeout_count     - timed-out sequences, saturating (optional)
// Options     : RFDC_NCO_SEQ_STATUS_CNT_EN adds seq_count / timeout_count.
// Revision    : 1.0 - initial release
// ============================================================================
module rfdc_nco_reset_seq
  import rfdc_nco_seq_pkg::*;
#(
  parameter int                   NUM_TILES      = 4,
  parameter logic [NUM_TILES-1:0] TILE_MASK      = {NUM_TILES{1'b1}},
  parameter int                   SYSREF_WAIT    = 2,
  parameter int                   REQ_CYCLES     = 8,
  parameter int                   TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_nco_reset,
  input  logic                 sysref_stb,
  output logic [NUM_TILES-1:0] tile_nco_rst_req,
  input  logic [NUM_TILES-1:0] tile_nco_rst_ack,
  output logic                 nco_reset_done,
  output logic                 nco_reset_err,
  output logic                 seq_busy
`ifdef RFDC_NCO_SEQ_STATUS_CNT_EN
  ,
  output logic [15:0]          seq_count,
  output logic [7:0]           timeout_count
`endif
);

  localparam logic [SREF_CNT_W-1:0] c_sref_load = SREF_CNT_W'(SYSREF_WAIT);
  localparam logic [REQ_CNT_W-1:0]  c_req_load  = REQ_CNT_W'(REQ_CYCLES);
  localparam logic [TMO_CNT_W-1:0]  c_tmo_last  = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

  seq_state_t r_state, w_state_nxt;

  logic [NUM_TILES-1:0] r_req, w_req_nxt;
  logic r_done, w_done_nxt;
  logic r_err,  w_err_nxt;
  logic r_busy;

  logic w_sref_load, w_sref_dec, w_sref_tc;
  logic w_req_load,  w_req_dec,  w_req_tc;

  logic [TMO_CNT_W-1:0] r_tmo_cnt;
  logic w_tmo_clr, w_tmo_inc;

  logic w_acks_ok;
  logic w_tmo_hit;
  logic w_done_entry;
  logic w_timeout;

  // Acks from masked-off tiles are forced to look complete.
  assign w_acks_ok = ((tile_nco_rst_ack & TILE_MASK) == TILE_MASK);
  assign w_tmo_hit = (r_tmo_cnt == c_tmo_last);

  // --------------------------------------------------------------------------
  // Counters
  // --------------------------------------------------------------------------
  rfdc_seq_down_counter #(
    .WIDTH (SREF_CNT_W)
  ) u_sref_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_sref_load),
    .i_load_val (c_sref_load),
    .i_dec      (w_sref_dec),
    .o_tc       (w_sref_tc)
  );

  rfdc_seq_down_counter #(
    .WIDTH (REQ_CNT_W)
  ) u_req_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_req_load),
    .i_load_val (c_req_load),
    .i_dec      (w_req_dec),
    .o_tc       (w_req_tc)
  );

  // Timeout up-counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (w_tmo_clr) begin
      r_tmo_cnt <= '0;
    end else if (w_tmo_inc && (r_tmo_cnt != '1)) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_req   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      // Busy is registered from the next state so it tracks the state register.
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_req_nxt    = r_req;
    w_done_nxt   = r_done;
    w_err_nxt    = r_err;
    w_sref_load  = 1'b0;
    w_sref_dec   = 1'b0;
    w_req_load   = 1'b0;
    w_req_dec    = 1'b0;
    w_tmo_clr    = 1'b0;
    w_tmo_inc    = 1'b0;
    w_done_entry = 1'b0;
    w_timeout    = 1'b0;

    case (r_state)
      IDLE: begin
        w_req_nxt = '0;
        // A SYSREF coincident with start is not counted: the load wins.
        if (start_nco_reset) begin
          w_state_nxt = SYNC;
          w_done_nxt  = 1'b0;
          w_err_nxt   = 1'b0;
          w_sref_load = 1'b1;
        end
      end

      SYNC: begin
        if (sysref_stb) begin
          w_sref_dec = 1'b1;
          if (w_sref_tc) begin
            w_state_nxt = ASSERT;
            w_req_nxt   = TILE_MASK;
            w_req_load  = 1'b1;
          end
        end
      end

      ASSERT: begin
        // Entered with the counter at REQ_CYCLES; leaving on the cycle it
        // reads 1 gives exactly REQ_CYCLES cycles of request.
        if (w_req_tc) begin
          w_state_nxt = WAIT_ACK;
          w_req_nxt   = '0;
          w_tmo_clr   = 1'b1;
        end else begin
          w_req_dec = 1'b1;
        end
      end

      WAIT_ACK: begin
        // Done and error are raised on the DONE entry edge itself.
        if (w_acks_ok) begin
          w_state_nxt  = DONE;
          w_done_nxt   = 1'b1;
          w_done_entry = 1'b1;
        end else if (w_tmo_hit) begin
          w_state_nxt  = DONE;
          w_done_nxt   = 1'b1;
          w_err_nxt    = 1'b1;
          w_done_entry = 1'b1;
          w_timeout    = 1'b1;
        end else begin
          w_tmo_inc = 1'b1;
        end
      end

      DONE: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
        w_req_nxt   = '0;
      end
    endcase
  end

  assign tile_nco_rst_req = r_req;
  assign nco_reset_done   = r_done;
  assign nco_reset_err    = r_err;
  assign seq_busy         = r_busy;

  // --------------------------------------------------------------------------
  // Optional status counters
  // --------------------------------------------------------------------------
`ifdef RFDC_NCO_SEQ_STATUS_CNT_EN
  logic [15:0] r_seq_count;
  logic [7:0]  r_timeout_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seq_count     <= '0;
      r_timeout_count <= '0;
    end else begin
      if (w_done_entry) begin
        r_seq_count <= r_seq_count + 16'd1;  // wraps by design
      end
      if (w_timeout && (r_timeout_count != 8'hFF)) begin
        r_timeout_count <= r_timeout_count + 8'd1;
      end
    end
  end

  assign seq_count     = r_seq_count;
  assign timeout_count = r_timeout_count;
`else
  // Without the status counters these strobes have no consumer.
  logic w_unused_status;
  assign w_unused_status = w_done_entry ^ w_timeout;
`endif

endmodule : rfdc_nco_reset_seq
`default_nettype wire
